// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_code,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             ZeroExt,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB  = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BEQ    = 4'd10, S_JAL   = 4'd11,
        S_JR     = 4'd12, S_ERROR  = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // fetch/memwr flags feed the mem_ready-qualified (Mealy) strobes
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       zero_ext;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       done;
        logic       illegal;
        logic       fetch;
        logic       memwr;
    } ctrl_t;

    state_e           state_q, state_d;
    logic             run_q;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q;

    // Next-state selection; run_q holds FETCH for the edge that ends reset
    always_comb begin
        state_d = state_q;
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op_code)
                        OP_LW, OP_SW:     state_d = S_MEMADR;
                        OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR : S_RTEXEC;
                        OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                        OP_BEQ:           state_d = S_BEQ;
                        OP_JAL:           state_d = S_JAL;
                        default:          state_d = S_ERROR;
                    endcase
                end
                S_MEMADR: state_d = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
                S_RTEXEC: state_d = S_RTWB;
                S_IEXEC:  state_d = S_IWB;
                S_MEMWB, S_RTWB, S_IWB, S_BEQ, S_JAL, S_JR: state_d = S_FETCH;
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_ERROR;
            endcase
        end
    end

    // Moore decode of the upcoming state, so outputs leave a register
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.fetch     = 1'b1;
            end
            S_DECODE: ctrl_d.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b01;
                ctrl_d.done       = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.ior_d     = 1'b1;
                ctrl_d.memwr     = 1'b1;
            end
            S_RTEXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_RTWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 2'b01;
                ctrl_d.done      = 1'b1;
            end
            S_IEXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                if (op_code == OP_ANDI) begin
                    ctrl_d.alu_op   = 2'b11;
                    ctrl_d.zero_ext = 1'b1;
                end else begin
                    ctrl_d.alu_op   = 2'b00;
                    ctrl_d.zero_ext = 1'b0;
                end
            end
            S_IWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.done      = 1'b1;
            end
            S_BEQ: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'b01;
                ctrl_d.done          = 1'b1;
            end
            S_JAL: begin
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_source  = 2'b10;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = 2'b10;
                ctrl_d.mem_to_reg = 2'b10;
                ctrl_d.done       = 1'b1;
            end
            S_JR: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 2'b11;
                ctrl_d.done      = 1'b1;
            end
            S_ERROR: ctrl_d.illegal = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // State, registered controls and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            ctrl_q  <= ctrl_d;
            if (instr_done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.ior_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.fetch & mem_ready;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ZeroExt     = ctrl_q.zero_ext;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign instr_done  = ctrl_q.done | (ctrl_q.memwr & mem_ready);
    assign illegal_op  = ctrl_q.illegal;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level phase model, directed and
// random instruction streams, 32-bit and 4-bit counter instances in parallel.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_code = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b0;

    logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_asa, a_zx, a_done, a_ill;
    logic [1:0] a_asb, a_aop, a_pcs, a_m2r, a_rd;
    logic [31:0] a_cnt;
    logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_asa, b_zx, b_done, b_ill;
    logic [1:0] b_asb, b_aop, b_pcs, b_m2r, b_rd;
    logic [3:0] b_cnt;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
        .MemWrite(a_mwr), .IRWrite(a_irw), .RegWrite(a_rw), .ALUSrcA(a_asa),
        .ZeroExt(a_zx), .ALUSrcB(a_asb), .ALUOp(a_aop), .PCSource(a_pcs),
        .MemtoReg(a_m2r), .RegDst(a_rd), .instr_done(a_done), .illegal_op(a_ill),
        .instr_count(a_cnt)
    );

    multicycle_ctrl_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
        .MemWrite(b_mwr), .IRWrite(b_irw), .RegWrite(b_rw), .ALUSrcA(b_asa),
        .ZeroExt(b_zx), .ALUSrcB(b_asb), .ALUOp(b_aop), .PCSource(b_pcs),
        .MemtoReg(b_m2r), .RegDst(b_rd), .instr_done(b_done), .illegal_op(b_ill),
        .instr_count(b_cnt)
    );

    wire [20:0] word_a = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_asa, a_zx,
                          a_asb, a_aop, a_pcs, a_m2r, a_rd, a_done, a_ill};
    wire [20:0] word_b = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_asa, b_zx,
                          b_asb, b_aop, b_pcs, b_m2r, b_rd, b_done, b_ill};

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;

    typedef enum int {
        P_FETCH, P_DECODE, P_ADDR, P_RD, P_RDWB, P_WR, P_REXEC, P_RWB,
        P_IEXEC, P_IWB, P_BEQ, P_JAL, P_JR, P_ERR
    } ph_e;
    ph_e phs[$];

    // Expected control word for one cycle of a given instruction phase
    function automatic logic [20:0] exp_word(ph_e p, logic [5:0] op, logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, zx, dn, ill;
        logic [1:0] asb, aop, pcs, m2r, rd;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, zx, dn, ill} = 11'd0;
        {asb, aop, pcs, m2r, rd} = 10'd0;
        case (p)
            P_FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            P_DECODE: asb = 2'b11;
            P_ADDR:   begin asa = 1'b1; asb = 2'b10; end
            P_RD:     begin mrd = 1'b1; iord = 1'b1; end
            P_RDWB:   begin rw = 1'b1; m2r = 2'b01; dn = 1'b1; end
            P_WR:     begin mwr = 1'b1; iord = 1'b1; dn = mr; end
            P_REXEC:  begin asa = 1'b1; aop = 2'b10; end
            P_RWB:    begin rw = 1'b1; rd = 2'b01; dn = 1'b1; end
            P_IEXEC:  begin
                asa = 1'b1; asb = 2'b10;
                if (op == 6'b001100) begin aop = 2'b11; zx = 1'b1; end
            end
            P_IWB:    begin rw = 1'b1; dn = 1'b1; end
            P_BEQ:    begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; dn = 1'b1; end
            P_JAL:    begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; rd = 2'b10; m2r = 2'b10; dn = 1'b1; end
            P_JR:     begin pcw = 1'b1; pcs = 2'b11; dn = 1'b1; end
            P_ERR:    ill = 1'b1;
            default:  ill = 1'b0;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, zx, asb, aop, pcs, m2r, rd, dn, ill};
    endfunction

    task automatic build_phases(input logic [5:0] op, input logic [5:0] fn);
        phs.delete();
        phs.push_back(P_FETCH);
        phs.push_back(P_DECODE);
        case (op)
            6'b100011: begin phs.push_back(P_ADDR); phs.push_back(P_RD); phs.push_back(P_RDWB); end
            6'b101011: begin phs.push_back(P_ADDR); phs.push_back(P_WR); end
            6'b000000: begin
                if (fn == 6'b001000) phs.push_back(P_JR);
                else begin phs.push_back(P_REXEC); phs.push_back(P_RWB); end
            end
            6'b001000, 6'b001100: begin phs.push_back(P_IEXEC); phs.push_back(P_IWB); end
            6'b000100: phs.push_back(P_BEQ);
            6'b000011: phs.push_back(P_JAL);
            default: for (int k = 0; k < 20; k++) phs.push_back(P_ERR);
        endcase
    endtask

    task automatic check_vals(input string tag, input logic [20:0] exp);
        checks++;
        assert (word_a === exp) else begin
            errors++;
            $error("FAIL %s ctl32 got=%h exp=%h", tag, word_a, exp);
        end
        checks++;
        assert (word_b === exp) else begin
            errors++;
            $error("FAIL %s ctl4 got=%h exp=%h", tag, word_b, exp);
        end
        checks++;
        assert (a_cnt === 32'(model_cnt)) else begin
            errors++;
            $error("FAIL %s cnt32 got=%0d exp=%0d", tag, a_cnt, model_cnt);
        end
        checks++;
        assert (b_cnt === 4'(model_cnt)) else begin
            errors++;
            $error("FAIL %s cnt4 got=%0d exp=%0d", tag, b_cnt, 4'(model_cnt));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        model_cnt = 0;
        #1 check_vals("reset", 21'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One instruction; mem_ready low for fst FETCH / mst memory cycles, or
    // random when rnd; abort_cyc >= 0 asserts rst at that cycle instead
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fst, input int mst, input bit rnd, input int abort_cyc);
        int   i, cyc, fl, ml;
        logic mr;
        ph_e  p;
        logic [20:0] exp;
        i = 0; cyc = 0; fl = 0; ml = 0;
        build_phases(op, fn);
        while (i < phs.size()) begin
            @(negedge clk);
            p = phs[i];
            if (p == P_FETCH) begin
                op_code = 6'($urandom);
                funct   = 6'($urandom);
            end else begin
                op_code = op;
                funct   = fn;
            end
            if (rnd) mr = ($urandom_range(0, 3) != 0);
            else if (p == P_FETCH) mr = (fl >= fst);
            else if (p == P_RD || p == P_WR) mr = (ml >= mst);
            else mr = 1'($urandom_range(0, 1));
            if (p == P_FETCH && !mr) fl++;
            if ((p == P_RD || p == P_WR) && !mr) ml++;
            mem_ready = mr;
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                model_cnt = 0;
                #1 check_vals("abort", 21'd0);
                return;
            end
            exp = exp_word(p, op, mr);
            #1 check_vals(p.name(), exp);
            if (exp[1]) model_cnt++;
            if (!((p == P_FETCH || p == P_RD || p == P_WR) && !mr)) i++;
            cyc++;
        end
    endtask

    initial begin
        logic [5:0] rop, rfn;
        do_reset();
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, -1);  // add
        run_instr(6'b100011, 6'b000000, 2, 3, 1'b0, -1);  // lw, stalled
        run_instr(6'b101011, 6'b000000, 0, 0, 1'b0, -1);  // sw
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b0, -1);  // beq
        run_instr(6'b000011, 6'b000000, 0, 0, 1'b0, -1);  // jal
        run_instr(6'b000000, 6'b001000, 0, 0, 1'b0, -1);  // jr
        run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, -1);  // addi
        run_instr(6'b001100, 6'b000000, 0, 0, 1'b0, -1);  // andi
        run_instr(6'b101011, 6'b000000, 1, 2, 1'b0, -1);  // sw, stalled
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: begin rop = 6'b000000; rfn = 6'b100010; end
                1: begin rop = 6'b100011; rfn = 6'($urandom); end
                2: begin rop = 6'b101011; rfn = 6'($urandom); end
                3: begin rop = 6'b000000; rfn = 6'b001000; end
                4: begin rop = 6'b001000; rfn = 6'($urandom); end
                5: begin rop = 6'b001100; rfn = 6'($urandom); end
                6: begin rop = 6'b000100; rfn = 6'($urandom); end
                default: begin rop = 6'b000011; rfn = 6'($urandom); end
            endcase
            run_instr(rop, rfn, 0, 0, 1'b1, -1);
        end
        run_instr(6'b100011, 6'b000000, 0, 10, 1'b0, 4);  // rst inside MEMRD stall
        @(negedge clk);
        rst = 1'b0;
        run_instr(6'b000000, 6'b100101, 0, 0, 1'b0, -1);
        run_instr(6'b111111, 6'b000000, 0, 0, 1'b1, -1);  // illegal, 20 ERROR cycles
        do_reset();
        run_instr(6'b001000, 6'b000000, 0, 0, 1'b1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
